// File: rtl/bcd_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a multiplexed
// common-anode seven-segment scanner; blank and overflow digits are code 4'hF.
module bcd_scanner #(
  parameter int WIDTH       = 12,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [3:0]        data,
  output logic [DIGITS-1:0] digit_en
);

  localparam int BCDW = (DIGITS + 1) * 4;
  localparam int DW   = DIGITS * 4;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int PW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW   = (DIGITS > 2) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  function automatic logic [BCDW-1:0] add3_all(input logic [BCDW-1:0] b);
    logic [BCDW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      else                     r[i*4 +: 4] = b[i*4 +: 4];
    end
    return r;
  endfunction

  // Digit 0 is never blanked, so a zero value still shows a single "0".
  function automatic logic [DW-1:0] blank_lz(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic          lead;
    r    = d;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (d[i*4 +: 4] == 4'h0)) r[i*4 +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

  state_t            state_r;
  logic              busy_r;
  logic [WIDTH-1:0]  bin_r;
  logic [BCDW-1:0]   bcd_r;
  logic [CW-1:0]     cnt_r;
  logic              spill_r;
  logic [DW-1:0]     disp_r;
  logic              ovf_r;
  logic [PW-1:0]     pre_r;
  logic [IW-1:0]     idx_r;
  logic [3:0]        data_r;
  logic [DIGITS-1:0] en_r;

  logic [BCDW-1:0]   adj_s;
  logic [BCDW-1:0]   bcd_nxt_s;
  logic [WIDTH-1:0]  bin_nxt_s;
  logic              lost_s;
  logic              commit_s;
  logic              ovf_cmt_s;
  logic [DW-1:0]     disp_cmt_s;
  logic [DW-1:0]     disp_nxt_s;
  logic              pre_wrap_s;
  logic [PW-1:0]     pre_nxt_s;
  logic [IW-1:0]     idx_nxt_s;
  logic [3:0]        data_nxt_s;
  logic [DIGITS-1:0] en_nxt_s;

  // One double-dabble step: add-3 correction then shift {BCD, bin} left.
  always_comb begin
    adj_s = add3_all(bcd_r);
    {lost_s, bcd_nxt_s, bin_nxt_s} = {adj_s, bin_r, 1'b0};
  end

  // A bit shifted out of the guard nibble is remembered so it still flags overflow.
  always_comb begin
    commit_s  = (state_r == CONVERT) && (cnt_r == CNT_LAST);
    ovf_cmt_s = spill_r | lost_s | (bcd_nxt_s[BCDW-1 -: 4] != 4'h0);
    if (ovf_cmt_s) begin
      disp_cmt_s = {DW{1'b1}};
    end else if (BLANK_LZ) begin
      disp_cmt_s = blank_lz(bcd_nxt_s[DW-1:0]);
    end else begin
      disp_cmt_s = bcd_nxt_s[DW-1:0];
    end
    if (commit_s) disp_nxt_s = disp_cmt_s;
    else          disp_nxt_s = disp_r;
  end

  // Scanner next state; data is taken from the post-commit display so a commit
  // shows up on the enabled digit in the same edge.
  always_comb begin
    pre_wrap_s = (pre_r == PRE_LAST);
    if (pre_wrap_s) begin
      pre_nxt_s = {PW{1'b0}};
      if (idx_r == IDX_LAST) idx_nxt_s = {IW{1'b0}};
      else                   idx_nxt_s = idx_r + IW'(1);
    end else begin
      pre_nxt_s = pre_r + PW'(1);
      idx_nxt_s = idx_r;
    end
    data_nxt_s = disp_nxt_s[{idx_nxt_s, 2'b00} +: 4];
    for (int i = 0; i < DIGITS; i++) begin
      en_nxt_s[i] = (idx_nxt_s != IW'(i));
    end
  end

  // Conversion FSM; a load seen while converting is simply dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      bin_r   <= {WIDTH{1'b0}};
      bcd_r   <= {BCDW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      spill_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            bin_r   <= value;
            bcd_r   <= {BCDW{1'b0}};
            cnt_r   <= CNT_INIT;
            spill_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_r   <= bcd_nxt_s;
          bin_r   <= bin_nxt_s;
          cnt_r   <= cnt_r - CW'(1);
          spill_r <= spill_r | lost_s;
          if (cnt_r == CNT_LAST) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Display register, prescaler and digit strobe; free-running beside the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_r <= {DW{1'b1}};
      ovf_r  <= 1'b0;
      pre_r  <= {PW{1'b0}};
      idx_r  <= {IW{1'b0}};
      data_r <= 4'hF;
      en_r   <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      disp_r <= disp_nxt_s;
      if (commit_s) ovf_r <= ovf_cmt_s;
      pre_r  <= pre_nxt_s;
      idx_r  <= idx_nxt_s;
      data_r <= data_nxt_s;
      en_r   <= en_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign overflow = ovf_r;
  assign data     = data_r;
  assign digit_en = en_r;

endmodule
